resp_fifo_reader: RTL
=====================

# resp_fifo_reader

Consumer-side engine for the 21-bit response FIFO: drains a software-specified number of responses, splits each word into tag and payload, checks tag ordering, and presents results downstream through a valid/ready port. It sits between the response FIFO (registered `empty`, pop on `read`, data combinationally valid while not empty) and the PageRank accumulate stage. It never pops an empty FIFO and never pops beyond the requested count.

## Interface
- `WIDTH`, 21: response word width; must equal `TAG_W + DATA_W`.
- `TAG_W`, 5: tag field width, bits `[WIDTH-1:DATA_W]`.
- `DATA_W`, 16: payload field width, bits `[DATA_W-1:0]`.
- `CNT_W`, 10: width of the response-count field.

- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle pulse that begins a drain of `len` responses; honoured only in IDLE.
- `len` in CNT_W: number of responses to drain; sampled with `start`.
- `busy` out 1: high in DRAIN and DONE.
- `done` out 1: one-cycle pulse after the last response is accepted downstream.
- `err` out 1: sticky tag-sequence error; cleared by an honoured `start`.
- `fifo_empty` in 1: registered empty flag from the FIFO.
- `fifo_data` in WIDTH: FIFO head word; valid while `fifo_empty` = 0.
- `fifo_read` out 1: pop strobe; the FIFO advances on the same rising edge.
- `out_valid` out 1: downstream data valid.
- `out_ready` in 1: downstream accept.
- `out_tag` out TAG_W: tag of the presented response.
- `out_data` out DATA_W: payload of the presented response.

## Operation
- FSM states:
  - IDLE → DRAIN on `start`, when `len` ≠ 0.
  - IDLE → DONE on `start`, when `len` = 0.
  - DRAIN → DONE when `acc_cnt` reaches `len_q` on a downstream accept.
  - DONE → IDLE unconditionally after one cycle.
- An honoured `start` does the following: latch `len_q` = `len`; clear `pop_cnt`, `acc_cnt`, `exp_tag` and `err`.
- `fifo_read` = (state == DRAIN) & ~`fifo_empty` & (`buf_cnt` < 2) & (`pop_cnt` < `len_q`).
  - Combinational from registered signals only. There is no path from `out_ready`.
- On each pop:
  - `fifo_data` is written into a 2-entry output buffer.
  - `pop_cnt` increments.
  - Tag `fifo_data[WIDTH-1:DATA_W]` is compared with `exp_tag`. On a mismatch `err` is set.
  - `exp_tag` increments modulo 2^TAG_W and wraps 31 → 0.
- Output port:
  - `out_valid` = (`buf_cnt` ≠ 0).
  - `out_tag`/`out_data` come from the buffer head.
  - Accept = `out_valid` & `out_ready`. An accept pops the buffer and increments `acc_cnt`.
- A pop and an accept in the same cycle leave `buf_cnt` unchanged. Data order is preserved.
- `start` during DRAIN or DONE is ignored; counters are not disturbed.
- `done` is high exactly in the DONE state.
- When `len` = 0, `done` pulses in the cycle after `start` and no pop occurs.
- Reset mid-drain: all state returns to reset values and the buffer is emptied. Words already popped are lost. The FIFO's own reset is expected on the same `reset`.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `err` 0, `fifo_read` 0, `out_valid` 0, `out_tag` 0, `out_data` 0, all counters 0.
- Pop-to-output latency: word popped at edge t is presented with `out_valid` = 1 from cycle t+1.
- Throughput: one response per cycle sustained while `out_ready` = 1 and the FIFO is non-empty.
- `fifo_read` relies on `fifo_empty` being updated on the same edge as the pop. After a pop of the last entry, `fifo_empty` is 1 in the next cycle. Back-to-back pops are therefore safe.
- Backpressure: with `out_ready` = 0, at most 2 words are popped, then `fifo_read` stays 0.
- `done` is asserted in the cycle after the final accept edge. `busy` falls one cycle after `done`.

## Structure
- Shared package `resp_pkg` holds:
  - `WIDTH`/`TAG_W`/`DATA_W` constants;
  - tag/data bit-position constants;
  - the FSM state enum (IDLE, DRAIN, DONE).
- Sub-module `resp_skid_buf`: 2-entry FIFO buffer.
  - Inputs: push, data-in, pop.
  - Outputs: `buf_cnt`, head data, not-empty.
  - Asynchronous reset.
- The top level holds the FSM, the counters (`pop_cnt`, `acc_cnt`, `len_q`), `exp_tag` and `err`.

## Test plan
- Reset mid-drain:
  - Stimulus: assert `reset` with 2 words buffered.
  - Required: `out_valid` = 0, `busy` = 0, `err` = 0 immediately, since reset is asynchronous.
  - Then: a new `start` drains correctly from tag 0.
- Basic drain:
  - Stimulus: FIFO preloaded with tags 0..3, `out_ready` = 1, `start` with `len` = 4.
  - Required: 4 pops on consecutive cycles; outputs with tags 0..3 on cycles t+1..t+4; `done` one cycle later; `err` = 0.
- Backpressure:
  - Stimulus: `len` = 6, FIFO holds 6 words, `out_ready` = 0 for 10 cycles, then 1.
  - Required: exactly 2 pops during the stall; all 6 delivered in order afterwards; no pop after the 6th.
- Starved FIFO:
  - Stimulus: `fifo_empty` = 1 with words arriving one every 3 cycles, `len` = 3.
  - Required: `fifo_read` is never high while `fifo_empty` = 1; `done` follows the third accept.
- Tag wrap and error:
  - Stimulus: `len` = 34 with tags 0..31,0,5.
  - Required: the wrap 31 → 0 causes no error; the final tag 5 (expected 1) sets `err`, which stays high until the next `start`.
- Zero length and ignored start:
  - Stimulus: `start` with `len` = 0.
  - Required: `done` next cycle, no `fifo_read`.
  - Stimulus: `start` pulsed during DRAIN.
  - Required: counters unchanged.

Source files
------------

// File: rtl/resp_pkg.sv
// Shared constants and FSM state type for the response FIFO reader.
package resp_pkg;
  localparam int WIDTH  = 21;
  localparam int TAG_W  = 5;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 10;

  localparam int TAG_MSB  = WIDTH - 1;
  localparam int TAG_LSB  = DATA_W;
  localparam int DATA_MSB = DATA_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/resp_skid_buf.sv
// Two-entry in-order buffer between FIFO pops and the downstream valid/ready port.
module resp_skid_buf #(
  parameter int DW = resp_pkg::WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [1:0]    o_cnt,
  output logic [DW-1:0] o_head,
  output logic          o_not_empty
);
  logic [DW-1:0] r_mem [0:1];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_cnt;

  // Storage, pointers and occupancy; caller never pushes when full or pops when empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_cnt       = r_cnt;
  assign o_head      = r_mem[r_rd_ptr];
  assign o_not_empty = (r_cnt != 2'd0);
endmodule

// File: rtl/resp_fifo_reader.sv
// Drains a requested number of tagged responses from the response FIFO,
// checks tag sequence and forwards tag/payload over a valid/ready port.
module resp_fifo_reader #(
  parameter int WIDTH  = resp_pkg::WIDTH,
  parameter int TAG_W  = resp_pkg::TAG_W,
  parameter int DATA_W = resp_pkg::DATA_W,
  parameter int CNT_W  = resp_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              fifo_empty,
  input  logic [WIDTH-1:0]  fifo_data,
  output logic              fifo_read,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_data
);
  import resp_pkg::*;

  state_e           r_state;
  logic [CNT_W-1:0] r_len_q;
  logic [CNT_W-1:0] r_pop_cnt;
  logic [CNT_W-1:0] r_acc_cnt;
  logic [TAG_W-1:0] r_exp_tag;
  logic             r_err;

  logic [1:0]       w_buf_cnt;
  logic [WIDTH-1:0] w_head;
  logic             w_buf_ne;
  logic             w_pop;
  logic             w_accept;
  logic             w_tag_bad;
  logic [CNT_W-1:0] w_acc_next;

  // Pop decision uses only registered state so out_ready never reaches the FIFO.
  assign w_pop      = (r_state == ST_DRAIN) && !fifo_empty &&
                      (w_buf_cnt < 2'd2) && (r_pop_cnt < r_len_q);
  assign w_accept   = w_buf_ne && out_ready;
  assign w_tag_bad  = (fifo_data[WIDTH-1:DATA_W] != r_exp_tag);
  assign w_acc_next = r_acc_cnt + CNT_W'(1);

  resp_skid_buf #(
    .DW(WIDTH)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_pop),
    .i_data      (fifo_data),
    .i_pop       (w_accept),
    .o_cnt       (w_buf_cnt),
    .o_head      (w_head),
    .o_not_empty (w_buf_ne)
  );

  // Drain FSM with its counters, expected-tag tracker and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_len_q   <= '0;
      r_pop_cnt <= '0;
      r_acc_cnt <= '0;
      r_exp_tag <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len_q   <= len;
            r_pop_cnt <= '0;
            r_acc_cnt <= '0;
            r_exp_tag <= '0;
            r_err     <= 1'b0;
            r_state   <= (len != '0) ? ST_DRAIN : ST_DONE;
          end
        end
        ST_DRAIN: begin
          if (w_pop) begin
            r_pop_cnt <= r_pop_cnt + CNT_W'(1);
            r_exp_tag <= r_exp_tag + TAG_W'(1);
            if (w_tag_bad) begin
              r_err <= 1'b1;
            end
          end
          if (w_accept) begin
            r_acc_cnt <= w_acc_next;
            if (w_acc_next == r_len_q) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign err       = r_err;
  assign fifo_read = w_pop;
  assign out_valid = w_buf_ne;
  assign out_tag   = w_head[WIDTH-1:DATA_W];
  assign out_data  = w_head[DATA_W-1:0];
endmodule
